// File: rtl/gate_pkg.sv
// gate_pkg: op encoding shared by the gate pipeline
package gate_pkg;
  typedef logic [2:0] op_t;
  localparam op_t OP_NOT     = 3'd0;
  localparam op_t OP_AND     = 3'd1;
  localparam op_t OP_OR      = 3'd2;
  localparam op_t OP_NAND    = 3'd3;
  localparam op_t OP_NOR     = 3'd4;
  localparam op_t OP_XOR     = 3'd5;
  localparam op_t OP_XNOR    = 3'd6;
  localparam op_t OP_ILLEGAL = 3'd7;
endpackage

// File: rtl/gate_op_core.sv
// gate_op_core: combinational bitwise gate selected by op
module gate_op_core import gate_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);
  always_comb begin
    y   = op == OP_NOT  ? ~a :
          op == OP_AND  ? a & b :
          op == OP_OR   ? a | b :
          op == OP_NAND ? ~(a & b) :
          op == OP_NOR  ? ~(a | b) :
          op == OP_XOR  ? a ^ b :
          op == OP_XNOR ? ~(a ^ b) : '0;
    err = op == OP_ILLEGAL;
  end
endmodule

// File: rtl/gate_array_pipe.sv
// gate_array_pipe: two-stage valid/ready gate pipeline with flags and saturating op counter
module gate_array_pipe import gate_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  op_t              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_count
);
  logic             s1_valid, s2_valid, s1_adv, err;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, y;
  gate_op_core #(.WIDTH(WIDTH)) u_core (.op(s1_op), .a(s1_a), .b(s1_b), .y(y), .err(err));
  always_comb begin
    s1_adv    = !s2_valid || out_ready;
    in_ready  = !s1_valid || s1_adv;
    out_valid = s2_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_NOT;
      out_y    <= '0;
      out_zero <= 1'b0;
      out_ones <= 1'b0;
      out_par  <= 1'b0;
      out_err  <= 1'b0;
      op_count <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= in_op;
      end
      if (s1_adv) s2_valid <= s1_valid;
      if (s1_valid && s1_adv) begin
        out_y    <= y;
        out_zero <= ~|y;
        out_ones <= &y;
        out_par  <= ^y;
        out_err  <= err;
      end
      op_count <= cnt_clr ? '0 : (out_valid && out_ready && ~&op_count) ? op_count + 1'b1 : op_count;
    end
  end
endmodule

// File: tb/tb_gate_array_pipe.sv
// tb_gate_array_pipe: randomized and directed checks of gate_array_pipe against a truth-table queue model
module tb_gate_array_pipe;
  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, cnt_clr;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       in_ready, out_valid, out_zero, out_ones, out_par, out_err;
  logic [7:0] out_y;
  logic [15:0] op_count;
  logic       in_ready2, out_valid2, out_zero2, out_ones2, out_par2, out_err2;
  logic [7:0] out_y2;
  logic [1:0] op_count2;
  typedef struct {int k; logic [7:0] y; logic err;} item_t;
  item_t       q[$];
  logic [11:0] cap[$];
  int          checks = 0, errors = 0, cyc = 0, cnt = 0, cnt2 = 0;
  int          dut_acc = 0, obs_hs = 0, acc = 0;
  always #5 clk = ~clk;
  gate_array_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_ones(out_ones), .out_par(out_par), .out_err(out_err), .cnt_clr(cnt_clr), .op_count(op_count)
  );
  gate_array_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2), .out_zero(out_zero2),
    .out_ones(out_ones2), .out_par(out_par2), .out_err(out_err2), .cnt_clr(cnt_clr), .op_count(op_count2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [7:0] ref_y(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] tt[8];
    logic [7:0] r;
    logic [1:0] idx;
    tt = '{4'b0011, 4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      idx  = {a[i], b[i]};
      r[i] = tt[op][idx];
    end
    return r;
  endfunction
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic ordy, input logic clr, input logic r);
    logic ev, er, ihs, ohs;
    logic [11:0] obs;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy; cnt_clr = clr; rst = r;
    #2;
    ev = q.size() > 0 && q[0].k < cyc;
    er = q.size() < 2 || ordy;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_y", out_y, q[0].y);
      chk("out_err", out_err, q[0].err);
      chk("out_zero", out_zero, q[0].y == 8'h00);
      chk("out_ones", out_ones, q[0].y == 8'hFF);
      chk("out_par", out_par, $countones(q[0].y) % 2);
    end
    chk("op_count", op_count, cnt);
    chk("op_count_w2", op_count2, cnt2);
    obs = {out_err, out_zero, out_ones, out_par, out_y};
    if (in_valid && in_ready) dut_acc++;
    if (out_valid && out_ready) obs_hs++;
    ihs = v && er;
    ohs = ev && ordy;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      cnt  = 0;
      cnt2 = 0;
    end else begin
      if (ohs) begin
        cap.push_back(obs);
        void'(q.pop_front());
      end
      if (ihs) begin
        q.push_back('{k: cyc, y: ref_y(op, a, b), err: op == 3'd7});
        acc++;
      end
      cnt  = clr ? 0 : ohs ? (cnt < 65535 ? cnt + 1 : cnt) : cnt;
      cnt2 = clr ? 0 : ohs ? (cnt2 < 3 ? cnt2 + 1 : cnt2) : cnt2;
    end
    #1;
  endtask
  task automatic do_reset();
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    cap.delete();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    logic [7:0] tt_exp[7];
    int budget;
    tt_exp = '{8'h0F, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 0; cnt_clr = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_y", out_y, 8'h00);
    chk("rst_flags", {out_zero, out_ones, out_par, out_err}, 4'b0000);
    chk("rst_op_count", op_count, 0);
    rst = 0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 7; i++) step(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("tt_count", cap.size(), 7);
    for (int i = 0; i < 7 && i < cap.size(); i++) chk($sformatf("tt_op%0d", i), cap[i][7:0], tt_exp[i]);
    chk("tt_op_count", op_count, 7);
    do_reset();
    step(1'b1, 8'hFF, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h01, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("flag_count", cap.size(), 3);
    if (cap.size() == 3) begin
      chk("flag_illegal", cap[0], 12'hC00);
      chk("flag_ones", cap[1], 12'h2FF);
      chk("flag_par", cap[2], 12'h101);
    end
    do_reset();
    dut_acc = 0;
    step(1'b1, 8'hF0, 8'hCC, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 8'hCC, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 8'hCC, 3'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 8'hCC, 3'd5, 1'b0, 1'b0, 1'b0);
    chk("bp_accepts", dut_acc, 2);
    chk("bp_hold_y", out_y, 8'hC0);
    step(1'b1, 8'hF0, 8'hCC, 3'd5, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("bp_count", cap.size(), 3);
    if (cap.size() == 3) begin
      chk("bp_y0", cap[0][7:0], 8'hC0);
      chk("bp_y1", cap[1][7:0], 8'hFC);
      chk("bp_y2", cap[2][7:0], 8'h3C);
    end
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h12, 8'h34, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("sat_w2", op_count2, 2'd3);
    chk("sat_w16", op_count, 5);
    step(1'b1, 8'h12, 8'h34, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0);
    chk("clr_hs_count", op_count, 0);
    chk("clr_hs_count_w2", op_count2, 0);
    step(1'b1, 8'hAA, 8'h55, 3'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 8'h55, 3'd6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_op_count", op_count, 0);
    cap.delete();
    step(1'b1, 8'hF0, 8'hCC, 3'd4, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("mid_rst_count", cap.size(), 1);
    if (cap.size() == 1) chk("mid_rst_y", cap[0][7:0], 8'h03);
    do_reset();
    acc = 0;
    obs_hs = 0;
    budget = 0;
    while (acc < 1000 && budget < 20000) begin
      step(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
           ($urandom % 50) == 0, 1'b0);
      budget++;
    end
    if (acc < 1000) chk("stream_budget", acc, 1000);
    idle(4);
    chk("stream_handshakes", obs_hs, acc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_array_pipe.md
Name: gate_array_pipe

Overview:
- Parametrised, pipelined successor to the fixed 1-bit gate set (NOT/AND/OR/NAND/NOR/XOR/XNOR).
- Applies a per-transaction selectable bitwise operation to WIDTH-bit operands.
- Two-stage valid/ready pipeline with result flags and a saturating completed-operation counter.
- Sits between a stimulus/register source and any consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the completed-operation counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B (ignored for NOT).
- in_op  input  3  operation select, encoding per package.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts this cycle.
- out_y  output  WIDTH  result.
- out_zero  output  1  out_y == 0.
- out_ones  output  1  out_y all ones.
- out_par  output  1  XOR-reduction of out_y.
- out_err  output  1  op code was illegal (7).
- cnt_clr  input  1  synchronous clear of op_count.
- op_count  output  CNT_W  number of completed output handshakes, saturating.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_y=0, all flags 0, op_count=0.
  - Reset mid-operation discards in-flight data.
  - in_ready=1 in the first cycle after reset is released.
- Op encoding (3 bits): 0 NOT A, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal.
  - Illegal op: y=0, err=1, flags computed from y=0 (zero=1, ones=0, par=0).
- Stage 1 registers a, b and op.
  - Accept condition: in_valid && in_ready.
  - in_ready = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready.
  - in_ready is combinational from out_ready (no skid buffer).
- Stage 2 registers y = f(op, a, b) plus zero/ones/par/err.
  - Stage 2 loads when s1_valid && s1_adv.
  - s2_valid clears on out_valid && out_ready when nothing new arrives.
- Latency:
  - A transaction accepted at edge N, with no stall, is on out_* in the cycle after edge N+1.
  - Throughput is 1 transaction per cycle when out_ready is held high.
- Backpressure:
  - While out_valid && !out_ready, out_y, flags and out_err hold stable.
  - With both stages full, in_ready=0.
  - No transaction is dropped or duplicated.
- Simultaneous events:
  - Output handshake and stage-1 advance in the same cycle: stage 2 is replaced by the new result; s2_valid stays 1.
  - Stage-1 advance and a new input accept in the same cycle are both permitted.
- Counter:
  - op_count increments on out_valid && out_ready.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority over an increment in the same cycle (result is 0).
- Width rule: all operations are bitwise at WIDTH bits with no carries; NOT ignores in_b entirely.

Decomposition:
- Shared package gate_pkg holds the op encoding constants OP_NOT..OP_XNOR and OP_ILLEGAL=7, plus a 3-bit op typedef.
- Sub-module gate_op_core: combinational, WIDTH-parametrised, op/a/b -> y/err.
  - Also instantiable standalone.
- Flags and the pipeline registers live in gate_array_pipe.

Test Plan:
- Truth table, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC for ops 0..6.
  - Required y: 0F, C0, FC, 3F, 03, 3C, C3, each 2 cycles after accept.
  - After 7 outputs, op_count=7.
- Illegal op and flags:
  - op=7, a=FF, b=FF -> y=00, err=1, zero=1, ones=0, par=0.
  - op=2, a=FF -> ones=1, par=0.
  - op=5, a=01, b=00 -> par=1.
- Backpressure: out_ready=0 while 3 back-to-back inputs are offered.
  - in_ready drops after 2 accepts; out_y stays stable.
  - After releasing out_ready, 3 results emerge in order with none lost.
- Counter:
  - CNT_W=2: 5 handshakes -> op_count=3 (saturated).
  - cnt_clr asserted in the same cycle as a handshake -> op_count=0.
- Reset mid-stream: rst asserted with both stages full.
  - Next cycle: out_valid=0, op_count=0, in_ready=1.
  - The next input yields only its own result.
- Streaming: random a/b/op for 1000 transactions against a reference model, with random out_ready at 50% duty.
  - Required: zero mismatches, and op_count equals the number of handshakes (mod saturation).
